// File: rtl/uart_tx_dev.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_dev
//  Purpose  : Memory-mapped 8N1 UART transmitter on the Bridge device bus.
//             CPU stores push bytes into a small TX FIFO; the FSM serialises
//             them LSB first on txd and raises a level interrupt when the
//             transmitter drains.
//  Ports    : clk    - system clock
//             reset  - synchronous, active-high reset
//             Addr   - word offset: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
//             WE     - single-cycle write strobe
//             WD     - write data
//             RD     - read data, combinational from Addr
//             IRQ    - level interrupt to Bridge HWInt
//             txd    - serial output, idle high
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_dev #(
    parameter int BAUD_DIV   = 2604,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ,
    output logic        txd
);

    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_BAUD_W = 16;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST  = c_PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_ie;
    logic                r_ovf;

    logic [1:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic                r_txd;
    logic                r_irq;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic        w_push;
    logic        w_pop;
    logic        w_accept;
    logic        w_empty;
    logic        w_full;
    logic        w_busy;
    logic        w_baud_end;
    logic        w_status_wr;
    logic        w_ctrl_wr;
    logic [1:0]  w_next_state;
    logic [7:0]  w_head;
    logic [23:0] w_unused_wd;

    assign w_unused_wd = WD[31:8];

    assign w_push      = WE && (Addr == 2'd0);
    assign w_status_wr = WE && (Addr == 2'd1);
    assign w_ctrl_wr   = WE && (Addr == 2'd2);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_CNT_FULL);
    assign w_busy      = (r_state != c_IDLE);
    assign w_baud_end  = (r_baud == c_BAUD_LAST);
    assign w_head      = r_mem[r_rptr];

    // A push into a full FIFO still fits when the transmitter frees the
    // head slot on the same edge.
    assign w_accept    = w_push && (!w_full || w_pop);

    // Next-state and pop decision; the pop is what moves the FIFO head
    // into the shift register, so both are decided together.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = c_START;
                end
            end
            c_START: begin
                if (w_baud_end) begin
                    w_next_state = c_DATA;
                end
            end
            c_DATA: begin
                if (w_baud_end && (r_bit == 3'd7)) begin
                    w_next_state = c_STOP;
                end
            end
            default: begin
                if (w_baud_end) begin
                    if (!w_empty) begin
                        // Back-to-back frame: no idle cycle between stop and start
                        w_pop        = 1'b1;
                        w_next_state = c_START;
                    end else begin
                        w_next_state = c_IDLE;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage (contents need no reset; count/pointers qualify them)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= WD[7:0];
        end
    end

    // ------------------------------------------------------------------
    // FIFO control and programmer-visible registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ie    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + c_PTR_W'(1);
            end

            if (w_accept && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - c_CNT_W'(1);
            end

            if (w_push && !w_accept) begin
                r_ovf <= 1'b1;
            end else if (w_status_wr) begin
                r_ovf <= 1'b0;
            end

            if (w_ctrl_wr) begin
                r_ie <= WD[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM and serial datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_irq   <= r_ie && w_empty && (w_next_state == c_IDLE);

            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_txd   <= 1'b0;
                        r_baud  <= '0;
                    end
                end
                c_START: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        r_bit  <= 3'd0;
                        r_txd  <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                c_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_txd <= 1'b1;
                        end else begin
                            // shift[1] becomes the next bit on the line
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                default: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_txd   <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        RD = 32'd0;
        case (Addr)
            2'd1:    RD = {27'd0, r_ovf, r_ie, w_empty, w_full, w_busy};
            2'd2:    RD = {31'd0, r_ie};
            default: RD = 32'd0;
        endcase
    end

    assign txd = r_txd;
    assign IRQ = r_irq;

endmodule
`default_nettype wire

// File: doc/uart_tx_dev.md
Name: uart_tx_dev

Overview:
- Memory-mapped UART transmitter peripheral on the Bridge device bus: the responder to CPU store/load accesses and the driver of the board uart_txd pin.
- CPU stores bytes into a 4-entry TX FIFO; the block serialises them as 8N1 frames, LSB first.
- Raises a level interrupt on HWInt when transmission drains.
- Instantiated by Bridge, which decodes the device base address and passes word offsets.

Parameters:
- BAUD_DIV, 2604, clock cycles per bit (25 MHz / 9600); legal range 2..65535.
- FIFO_DEPTH, 4, TX FIFO entries; power of two.

Ports:
- clk  input  1  system clock (clk1 domain).
- reset  input  1  synchronous, active-high reset.
- Addr  input  2  word offset within device: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
- WE  input  1  write strobe from Bridge, valid for one cycle per store.
- WD  input  32  write data.
- RD  output  32  read data, combinational from Addr.
- IRQ  output  1  interrupt request to Bridge HWInt.
- txd  output  1  serial output, idle high.

Behaviour:
- Reset values, applied on the edge where reset=1 (overrides everything, including mid-frame):
  - txd=1; IRQ=0; FIFO empty (count=0); state IDLE.
  - IE=0; OVF=0; bit and baud counters 0.
- Registers:
  - DATA write: push WD[7:0] to FIFO. DATA read returns 0.
  - STATUS read: {27'b0, OVF, IE, EMPTY, FULL, BUSY}.
    - BUSY = state != IDLE.
    - FULL = count == FIFO_DEPTH.
    - EMPTY = count == 0.
  - STATUS write (any data): clears OVF.
  - CTRL write: IE <= WD[0]. CTRL read returns {31'b0, IE}.
  - Offset 3: writes ignored, reads return 0.
- FIFO:
  - Push at an edge with WE=1 and Addr=0.
  - Push while FULL with no pop that cycle: byte dropped, OVF set (sticky).
  - Simultaneous push and pop while FULL: push accepted, count stays FIFO_DEPTH, OVF unchanged.
  - Simultaneous push and pop while not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Transmit FSM:
  - States: IDLE, START, DATA, STOP. txd is a registered output.
  - IDLE: if count != 0, pop head into shift register, txd <= 0, go to START, baud counter <= 0.
    - Latency: byte pushed at edge k into an empty FIFO with FSM idle -> txd falls at edge k+1.
  - Each of START, DATA bit, and STOP holds txd for exactly BAUD_DIV cycles; the baud counter counts 0..BAUD_DIV-1.
  - START -> DATA: txd <= shift[0], bit index 0.
  - DATA: shift right each bit period; after bit 7 go to STOP with txd <= 1.
  - STOP end:
    - If count != 0: pop immediately, txd <= 0, go to START. Back-to-back frames have no extra idle cycle.
    - Otherwise go to IDLE.
  - Frame length: exactly 10*BAUD_DIV cycles.
- Interrupt:
  - IRQ registered: IRQ <= IE & EMPTY & (next state == IDLE).
  - Asserted one cycle after the last stop bit completes with an empty FIFO.
  - Deasserts on the edge after a DATA push or IE cleared.
- Writes never stall. The Bridge bus has no wait states; RD is valid in the same cycle as Addr.

Test Plan (BAUD_DIV=4, FIFO_DEPTH=4):
- Reset, then idle for 20 cycles -> txd=1, IRQ=0, STATUS=0x04.
- Write DATA=0x55 at edge k -> txd low for edges k+1..k+4, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles. BUSY=1 throughout; STATUS returns 0x04 after edge k+40.
- Write CTRL=1, then DATA=0xA3 -> IRQ rises exactly one cycle after the stop bit ends. A subsequent DATA write drops IRQ on the next edge.
- Write 5 bytes 0x01..0x05 in consecutive cycles while idle:
  - First byte is popped immediately, so all 5 are accepted and OVF=0.
  - The frames run back-to-back with no idle gap: 200 cycles total.
- Burst 6 bytes in consecutive cycles:
  - Sixth byte is dropped; STATUS reads 0x13 (OVF, FULL, BUSY).
  - A STATUS write clears OVF.
  - Only 5 frames are emitted.
- Assert reset mid-DATA bit 3 -> txd=1 on the next edge; FIFO empty, IE=0, no further frame emitted.
